// File: rtl/dispatch_shared_bank_pkg.sv
// Shared definitions for the dispatch stage: opcodes, lane request/result
// records and the per-lane op semantics used by every lane ALU.
package dispatch_bank_pkg;

  localparam int PKG_NUM_LANES  = 4;
  localparam int PKG_NUM_GROUPS = 8;
  localparam int PKG_SHARED_W   = 32;
  localparam int PKG_PAYLOAD_W  = 64;
  localparam int PKG_ID_W       = 8;
  localparam int PKG_GROUP_W    = $clog2(PKG_NUM_GROUPS);
  localparam int OP_W           = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_READ  = 3'd1,
    OP_WRITE = 3'd2,
    OP_ADD   = 3'd3,
    OP_MAX   = 3'd4
  } dispatch_bank_op_e;

  typedef struct packed {
    logic [OP_W-1:0]         op;
    logic [PKG_GROUP_W-1:0]  group;
    logic [PKG_SHARED_W-1:0] operand;
  } lane_req_t;

  typedef struct packed {
    logic [PKG_SHARED_W-1:0] new_val;
    logic [PKG_SHARED_W-1:0] result;
    logic                    writes;
  } lane_out_t;

  // Reserved opcodes fall through to the NOP default: no write, result 0.
  function automatic lane_out_t lane_apply(input logic [OP_W-1:0]         op,
                                           input logic [PKG_SHARED_W-1:0] old,
                                           input logic [PKG_SHARED_W-1:0] operand);
    lane_out_t r;
    r.new_val = old;
    r.result  = '0;
    r.writes  = 1'b0;
    case (op)
      OP_READ:  r.result = old;
      OP_WRITE: begin
        r.new_val = operand;
        r.result  = old;
        r.writes  = 1'b1;
      end
      OP_ADD: begin
        r.new_val = old + operand;
        r.result  = old;
        r.writes  = 1'b1;
      end
      OP_MAX: begin
        r.new_val = (operand > old) ? operand : old;
        r.result  = old;
        r.writes  = 1'b1;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic op_counts(input logic [OP_W-1:0] op);
    return op inside {OP_READ, OP_WRITE, OP_ADD, OP_MAX};
  endfunction

endpackage

// File: rtl/dispatch_shared_bank_if.sv
// Fetch-side input beat, execute-side output beat and sideband of the
// dispatch stage; slave is the dispatch stage, master is its environment.
interface dispatch_shared_bank_if
  import dispatch_bank_pkg::*;
#(
  parameter int NUM_LANES  = PKG_NUM_LANES,
  parameter int NUM_GROUPS = PKG_NUM_GROUPS,
  parameter int SHARED_W   = PKG_SHARED_W,
  parameter int PAYLOAD_W  = PKG_PAYLOAD_W,
  parameter int ID_W       = PKG_ID_W
);
  localparam int GROUP_W = $clog2(NUM_GROUPS);

  logic                           in_valid;
  logic                           in_ready;
  logic [NUM_LANES-1:0]           in_active;
  logic [NUM_LANES*OP_W-1:0]      in_op;
  logic [NUM_LANES*GROUP_W-1:0]   in_group;
  logic [NUM_LANES*SHARED_W-1:0]  in_operand;
  logic [NUM_LANES*PAYLOAD_W-1:0] in_payload;
  logic [ID_W-1:0]                in_id;
  logic                           bank_clear;
  logic                           out_valid;
  logic                           out_ready;
  logic [NUM_LANES-1:0]           out_active;
  logic [NUM_LANES*SHARED_W-1:0]  out_result;
  logic [NUM_LANES*PAYLOAD_W-1:0] out_payload;
  logic [ID_W-1:0]                out_id;
  logic [NUM_GROUPS-1:0]          dbg_wr_mask;
  logic [31:0]                    stat_ops;

  modport slave (
    input  in_valid, in_active, in_op, in_group, in_operand, in_payload, in_id,
           bank_clear, out_ready,
    output in_ready, out_valid, out_active, out_result, out_payload, out_id,
           dbg_wr_mask, stat_ops
  );

  modport master (
    output in_valid, in_active, in_op, in_group, in_operand, in_payload, in_id,
           bank_clear, out_ready,
    input  in_ready, out_valid, out_active, out_result, out_payload, out_id,
           dbg_wr_mask, stat_ops
  );

endinterface

// File: rtl/dispatch_shared_bank_lane_alu.sv
// One lane of the in-beat chain: applies the lane's op to the entry value
// left by the lanes before it.
module dispatch_lane_alu
  import dispatch_bank_pkg::*;
(
  input  logic                    en,
  input  logic [OP_W-1:0]         op,
  input  logic [PKG_SHARED_W-1:0] old,
  input  logic [PKG_SHARED_W-1:0] operand,
  output logic [PKG_SHARED_W-1:0] new_val,
  output logic [PKG_SHARED_W-1:0] result,
  output logic                    wr,
  output logic                    cnt
);

  lane_out_t r;

  always_comb begin
    r       = lane_apply(en ? op : OP_NOP, old, operand);
    new_val = r.new_val;
    result  = r.result;
    wr      = r.writes;
    cnt     = en && op_counts(op);
  end

endmodule

// File: rtl/dispatch_shared_bank.sv
// Multi-lane dispatch stage over a banked shared-register file with a single
// output register, synchronous bank clear, write mask and op counter.
module dispatch_shared_bank
  import dispatch_bank_pkg::*;
#(
  parameter int NUM_LANES  = PKG_NUM_LANES,
  parameter int NUM_GROUPS = PKG_NUM_GROUPS,
  parameter int SHARED_W   = PKG_SHARED_W,
  parameter int PAYLOAD_W  = PKG_PAYLOAD_W,
  parameter int ID_W       = PKG_ID_W
) (
  input logic                   clk,
  input logic                   rst,
  dispatch_shared_bank_if.slave bus
);
  localparam int GROUP_W = $clog2(NUM_GROUPS);

  typedef logic [NUM_GROUPS-1:0][SHARED_W-1:0] bank_t;

  bank_t                              bank;
  bank_t                              bank_next;
  logic                               out_valid_q;
  logic [NUM_LANES-1:0]               out_active_q;
  logic [NUM_LANES*SHARED_W-1:0]      out_result_q;
  logic [NUM_LANES*PAYLOAD_W-1:0]     out_payload_q;
  logic [ID_W-1:0]                    out_id_q;
  logic [NUM_GROUPS-1:0]              wr_mask_q;
  logic [31:0]                        stat_ops_q;
  logic                               in_ready;
  logic                               accept;
  logic [NUM_LANES-1:0]               lane_cnt;
  logic [NUM_LANES-1:0][NUM_GROUPS-1:0] lane_hit;
  logic [NUM_LANES*SHARED_W-1:0]      lane_result;
  logic [NUM_LANES*PAYLOAD_W-1:0]     lane_payload;
  logic [NUM_GROUPS-1:0]              mask_next;
  logic [32:0]                        ops_inc;
  logic [32:0]                        ops_sum;

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Each lane sees the bank as left by the lanes below it; the last view is the committed bank.
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_req_t           req;
    bank_t               view_in;
    bank_t               view_out;
    logic                in_range;
    logic                lane_en;
    logic                wr;
    logic [SHARED_W-1:0] old;
    logic [SHARED_W-1:0] new_val;
    logic [SHARED_W-1:0] result;

    assign req.op      = bus.in_op[OP_W*k +: OP_W];
    assign req.group   = bus.in_group[GROUP_W*k +: GROUP_W];
    assign req.operand = bus.in_operand[SHARED_W*k +: SHARED_W];

    if (k == 0) begin : g_head
      assign view_in = bank;
    end else begin : g_link
      assign view_in = g_lane[k-1].view_out;
    end

    if (NUM_GROUPS == (1 << GROUP_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = int'(req.group) < NUM_GROUPS;
    end

    assign lane_en = bus.in_active[k] && in_range;
    assign old     = in_range ? view_in[req.group] : '0;

    dispatch_lane_alu u_alu (
      .en      (lane_en),
      .op      (req.op),
      .old     (old),
      .operand (req.operand),
      .new_val (new_val),
      .result  (result),
      .wr      (wr),
      .cnt     (lane_cnt[k])
    );

    always_comb begin
      view_out = view_in;
      if (wr) view_out[req.group] = new_val;
    end

    assign lane_hit[k] = wr ? (NUM_GROUPS'(1) << req.group) : '0;
    assign lane_result[SHARED_W*k +: SHARED_W] = result;
    assign lane_payload[PAYLOAD_W*k +: PAYLOAD_W] =
      bus.in_active[k] ? bus.in_payload[PAYLOAD_W*k +: PAYLOAD_W] : '0;

    if (k == NUM_LANES - 1) begin : g_tail
      assign bank_next = view_out;
    end
  end

  always_comb begin
    ops_inc   = '0;
    mask_next = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      ops_inc   = ops_inc + 33'(lane_cnt[k]);
      mask_next = mask_next | lane_hit[k];
    end
    ops_sum = {1'b0, stat_ops_q} + ops_inc;
  end

  // Clear is applied after the beat's writes so it always wins on a coincident accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_active_q  <= '0;
      out_result_q  <= '0;
      out_payload_q <= '0;
      out_id_q      <= '0;
      wr_mask_q     <= '0;
      stat_ops_q    <= '0;
      bank          <= '0;
    end else begin
      if (accept) begin
        out_valid_q   <= 1'b1;
        out_active_q  <= bus.in_active;
        out_result_q  <= lane_result;
        out_payload_q <= lane_payload;
        out_id_q      <= bus.in_id;
        wr_mask_q     <= mask_next;
        stat_ops_q    <= ops_sum[32] ? '1 : ops_sum[31:0];
      end else begin
        wr_mask_q <= '0;
        if (bus.out_ready) out_valid_q <= 1'b0;
      end
      if (bus.bank_clear) bank <= '0;
      else if (accept)    bank <= bank_next;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_active  = out_active_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_payload = out_payload_q;
  assign bus.out_id      = out_id_q;
  assign bus.dbg_wr_mask = wr_mask_q;
  assign bus.stat_ops    = stat_ops_q;

endmodule

// File: tb/tb_dispatch_shared_bank.sv
// Self-checking bench for dispatch_shared_bank: directed scenarios plus a
// randomized stream against a sequential lane-by-lane reference model.
module tb_dispatch_shared_bank;
  import dispatch_bank_pkg::*;

  localparam int NL = 4;
  localparam int NG = 8;
  localparam int SW = 32;
  localparam int PW = 64;
  localparam int IW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dispatch_shared_bank_if #(.NUM_LANES(NL), .NUM_GROUPS(NG), .SHARED_W(SW),
                            .PAYLOAD_W(PW), .ID_W(IW)) bus ();

  dispatch_shared_bank #(.NUM_LANES(NL), .NUM_GROUPS(NG), .SHARED_W(SW),
                         .PAYLOAD_W(PW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Beat under construction
  logic [2:0]    op_t  [NL];
  logic [2:0]    grp_t [NL];
  logic [SW-1:0] opd_t [NL];
  logic [PW-1:0] pay_t [NL];
  logic [NL-1:0] act_t;
  logic [IW-1:0] id_t;
  logic          clr_t;

  // Reference state and expectations
  logic [SW-1:0]    mb [NG];
  logic [31:0]      m_ops;
  logic [NL*SW-1:0] exp_result;
  logic [NL*PW-1:0] exp_payload;
  logic [NL-1:0]    exp_active;
  logic [IW-1:0]    exp_id;
  logic [NG-1:0]    exp_mask;

  task automatic model_reset();
    for (int g = 0; g < NG; g++) mb[g] = '0;
    m_ops = '0;
  endtask

  task automatic clear_lanes();
    act_t = '0;
    clr_t = 1'b0;
    id_t  = IW'($urandom);
    for (int k = 0; k < NL; k++) begin
      op_t[k]  = OP_NOP;
      grp_t[k] = '0;
      opd_t[k] = '0;
      pay_t[k] = {$urandom, $urandom};
    end
  endtask

  task automatic set_beat();
    bus.in_active  = act_t;
    bus.in_id      = id_t;
    bus.bank_clear = clr_t;
    for (int k = 0; k < NL; k++) begin
      bus.in_op[3*k +: 3]        = op_t[k];
      bus.in_group[3*k +: 3]     = grp_t[k];
      bus.in_operand[SW*k +: SW] = opd_t[k];
      bus.in_payload[PW*k +: PW] = pay_t[k];
    end
  endtask

  // Lanes applied one after another against the model bank, then the clear.
  task automatic model_beat();
    logic [SW-1:0] old;
    exp_result  = '0;
    exp_payload = '0;
    exp_mask    = '0;
    exp_active  = act_t;
    exp_id      = id_t;
    for (int k = 0; k < NL; k++) begin
      if (act_t[k]) exp_payload[PW*k +: PW] = pay_t[k];
      if (act_t[k] && op_t[k] >= 3'd1 && op_t[k] <= 3'd4) begin
        old = mb[grp_t[k]];
        exp_result[SW*k +: SW] = old;
        if (m_ops != 32'hFFFF_FFFF) m_ops = m_ops + 1;
        if (op_t[k] >= 3'd2) exp_mask[grp_t[k]] = 1'b1;
        if (op_t[k] == 3'd2) mb[grp_t[k]] = opd_t[k];
        if (op_t[k] == 3'd3) mb[grp_t[k]] = old + opd_t[k];
        if (op_t[k] == 3'd4 && opd_t[k] > old) mb[grp_t[k]] = opd_t[k];
      end
    end
    if (clr_t) for (int g = 0; g < NG; g++) mb[g] = '0;
  endtask

  task automatic drive_beat();
    set_beat();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    model_beat();
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
    bus.bank_clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_active = '0; bus.in_op = '0; bus.in_group = '0;
    bus.in_operand = '0; bus.in_payload = '0; bus.in_id = '0;
    bus.bank_clear = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if (bus.stat_ops !== 32'd0) begin n_bad++; $display("[TB] FAIL rst_stat_ops got=%0d exp=0", bus.stat_ops); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_wr_mask got=%h exp=00", bus.dbg_wr_mask); end
    n_cmp++; if (bus.out_result !== '0 || bus.out_payload !== '0 || bus.out_id !== '0 || bus.out_active !== '0)
      begin n_bad++; $display("[TB] FAIL rst_outputs got=%h/%h exp=0", bus.out_result, bus.out_id); end
  endtask

  task automatic test_write_read();
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) begin op_t[k] = OP_WRITE; grp_t[k] = 3'(k); opd_t[k] = 32'hA + 32'(k); end
    drive_beat();
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL wr_out_valid got=%b exp=1", bus.out_valid); end
    n_cmp++; if (bus.out_result !== '0) begin n_bad++; $display("[TB] FAIL wr_result got=%h exp=0", bus.out_result); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h0F) begin n_bad++; $display("[TB] FAIL wr_mask got=%h exp=0f", bus.dbg_wr_mask); end
    n_cmp++; if (bus.stat_ops !== 32'd4) begin n_bad++; $display("[TB] FAIL wr_stat_ops got=%0d exp=4", bus.stat_ops); end
    n_cmp++; if (bus.out_payload !== exp_payload || bus.out_id !== exp_id)
      begin n_bad++; $display("[TB] FAIL wr_payload_id got=%h/%h exp=%h/%h", bus.out_payload, bus.out_id, exp_payload, exp_id); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.dbg_wr_mask !== 8'h00)
      begin n_bad++; $display("[TB] FAIL idle_drain got=%b/%h exp=0/00", bus.out_valid, bus.dbg_wr_mask); end
    for (int k = 0; k < NL; k++) op_t[k] = OP_READ;
    drive_beat();
    n_cmp++; if (bus.out_result !== 128'h0000000D_0000000C_0000000B_0000000A)
      begin n_bad++; $display("[TB] FAIL rd_result got=%h exp=0000000d0000000c0000000b0000000a", bus.out_result); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h00 || bus.stat_ops !== 32'd8)
      begin n_bad++; $display("[TB] FAIL rd_mask_stat got=%h/%0d exp=00/8", bus.dbg_wr_mask, bus.stat_ops); end
  endtask

  task automatic test_chain();
    clear_lanes();
    act_t = 4'b0001; op_t[0] = OP_WRITE; grp_t[0] = 3'd2; opd_t[0] = 32'd5;
    drive_beat();
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) grp_t[k] = 3'd2;
    op_t[0] = OP_ADD; opd_t[0] = 32'd1;
    op_t[1] = OP_ADD; opd_t[1] = 32'd1;
    op_t[2] = OP_MAX; opd_t[2] = 32'd3;
    op_t[3] = OP_READ;
    drive_beat();
    n_cmp++; if (bus.out_result !== {32'd7, 32'd7, 32'd6, 32'd5})
      begin n_bad++; $display("[TB] FAIL chain_result got=%h exp=00000007000000070000000600000005", bus.out_result); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h04) begin n_bad++; $display("[TB] FAIL chain_mask got=%h exp=04", bus.dbg_wr_mask); end
    clear_lanes();
    act_t = 4'b0001; op_t[0] = OP_READ; grp_t[0] = 3'd2;
    drive_beat();
    n_cmp++; if (bus.out_result[31:0] !== 32'd7) begin n_bad++; $display("[TB] FAIL chain_final got=%h exp=7", bus.out_result[31:0]); end
  endtask

  task automatic test_wrap();
    clear_lanes();
    act_t = 4'b0001; op_t[0] = OP_WRITE; grp_t[0] = 3'd1; opd_t[0] = 32'hFFFF_FFFF;
    drive_beat();
    op_t[0] = OP_ADD; opd_t[0] = 32'd2;
    drive_beat();
    n_cmp++; if (bus.out_result[31:0] !== 32'hFFFF_FFFF) begin n_bad++; $display("[TB] FAIL wrap_add got=%h exp=ffffffff", bus.out_result[31:0]); end
    op_t[0] = OP_READ;
    drive_beat();
    n_cmp++; if (bus.out_result[31:0] !== 32'h0000_0001) begin n_bad++; $display("[TB] FAIL wrap_read got=%h exp=00000001", bus.out_result[31:0]); end
  endtask

  task automatic test_backpressure();
    logic [NL*SW-1:0] held;
    logic [31:0]      held_ops;
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) begin op_t[k] = OP_WRITE; grp_t[k] = 3'(4 + k); opd_t[k] = $urandom; end
    drive_beat();
    held     = exp_result;
    held_ops = m_ops;
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) begin op_t[k] = OP_ADD; grp_t[k] = 3'(4 + k); opd_t[k] = 32'($urandom_range(1, 100)); end
    set_beat();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL stall_in_ready got=%b exp=0", bus.in_ready); end
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_result !== held)
        begin n_bad++; $display("[TB] FAIL stall_hold got=%b/%h exp=1/%h", bus.out_valid, bus.out_result, held); end
      n_cmp++; if (bus.stat_ops !== held_ops || bus.dbg_wr_mask !== 8'h00)
        begin n_bad++; $display("[TB] FAIL stall_side got=%0d/%h exp=%0d/00", bus.stat_ops, bus.dbg_wr_mask, held_ops); end
    end
    bus.out_ready = 1'b1;
    model_beat();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.out_result !== exp_result || bus.out_id !== exp_id)
      begin n_bad++; $display("[TB] FAIL release_beat got=%h/%h exp=%h/%h", bus.out_result, bus.out_id, exp_result, exp_id); end
    for (int k = 0; k < NL; k++) op_t[k] = OP_READ;
    drive_beat();
    n_cmp++; if (bus.out_result !== exp_result)
      begin n_bad++; $display("[TB] FAIL stall_bank got=%h exp=%h", bus.out_result, exp_result); end
  endtask

  task automatic test_inactive_reserved();
    logic [31:0] prev;
    prev = m_ops;
    clear_lanes();
    act_t = 4'b0101;
    op_t[0] = OP_WRITE; grp_t[0] = 3'd4; opd_t[0] = 32'h1234;
    op_t[1] = OP_WRITE; grp_t[1] = 3'd5; opd_t[1] = 32'h77;
    op_t[2] = 3'd6;     grp_t[2] = 3'd5; opd_t[2] = 32'h99;
    drive_beat();
    n_cmp++; if (bus.stat_ops !== prev + 32'd1) begin n_bad++; $display("[TB] FAIL inact_stat got=%0d exp=%0d", bus.stat_ops, prev + 32'd1); end
    n_cmp++; if (bus.out_active !== 4'b0101) begin n_bad++; $display("[TB] FAIL inact_active got=%b exp=0101", bus.out_active); end
    n_cmp++; if (bus.out_result[95:32] !== 64'h0 || bus.out_payload[127:64] !== 64'h0)
      begin n_bad++; $display("[TB] FAIL inact_zero got=%h/%h exp=0/0", bus.out_result[95:32], bus.out_payload[127:64]); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h10) begin n_bad++; $display("[TB] FAIL inact_mask got=%h exp=10", bus.dbg_wr_mask); end
    clear_lanes();
    act_t = 4'b0001; op_t[0] = OP_READ; grp_t[0] = 3'd5;
    drive_beat();
    n_cmp++; if (bus.out_result !== exp_result) begin n_bad++; $display("[TB] FAIL inact_bank got=%h exp=%h", bus.out_result, exp_result); end
  endtask

  task automatic test_bank_clear();
    clear_lanes();
    act_t = 4'b0001; op_t[0] = OP_WRITE; grp_t[0] = 3'd3; opd_t[0] = 32'h55; clr_t = 1'b1;
    drive_beat();
    n_cmp++; if (bus.out_result[31:0] !== 32'hD) begin n_bad++; $display("[TB] FAIL clr_result got=%h exp=0000000d", bus.out_result[31:0]); end
    n_cmp++; if (bus.dbg_wr_mask !== 8'h08) begin n_bad++; $display("[TB] FAIL clr_mask got=%h exp=08", bus.dbg_wr_mask); end
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) begin op_t[k] = OP_READ; grp_t[k] = 3'(k); end
    drive_beat();
    n_cmp++; if (bus.out_result !== '0) begin n_bad++; $display("[TB] FAIL clr_read_lo got=%h exp=0", bus.out_result); end
    for (int k = 0; k < NL; k++) grp_t[k] = 3'(4 + k);
    drive_beat();
    n_cmp++; if (bus.out_result !== '0) begin n_bad++; $display("[TB] FAIL clr_read_hi got=%h exp=0", bus.out_result); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      clear_lanes();
      act_t = NL'($urandom);
      clr_t = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NL; k++) begin
        op_t[k]  = 3'($urandom_range(0, 7));
        grp_t[k] = 3'($urandom_range(0, (i % 2) ? 7 : 2));
        case ($urandom_range(0, 2))
          0:       opd_t[k] = $urandom;
          1:       opd_t[k] = 32'($urandom_range(0, 8));
          default: opd_t[k] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        endcase
      end
      drive_beat();
      n_cmp++; if (bus.out_result !== exp_result) begin n_bad++; $display("[TB] FAIL rnd_result beat=%0d got=%h exp=%h", i, bus.out_result, exp_result); end
      n_cmp++; if (bus.out_payload !== exp_payload) begin n_bad++; $display("[TB] FAIL rnd_payload beat=%0d got=%h exp=%h", i, bus.out_payload, exp_payload); end
      n_cmp++; if (bus.out_active !== exp_active || bus.out_id !== exp_id)
        begin n_bad++; $display("[TB] FAIL rnd_act_id beat=%0d got=%b/%h exp=%b/%h", i, bus.out_active, bus.out_id, exp_active, exp_id); end
      n_cmp++; if (bus.dbg_wr_mask !== exp_mask) begin n_bad++; $display("[TB] FAIL rnd_mask beat=%0d got=%h exp=%h", i, bus.dbg_wr_mask, exp_mask); end
      n_cmp++; if (bus.stat_ops !== m_ops) begin n_bad++; $display("[TB] FAIL rnd_stat beat=%0d got=%0d exp=%0d", i, bus.stat_ops, m_ops); end
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd_idle beat=%0d got=%b exp=0", i, bus.out_valid); end
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    clear_lanes();
    act_t = 4'b0011;
    op_t[0] = OP_WRITE; grp_t[0] = 3'd0; opd_t[0] = 32'hCAFE;
    op_t[1] = OP_WRITE; grp_t[1] = 3'd1; opd_t[1] = 32'hBEEF;
    drive_beat();
    set_beat();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rststall_valid got=%b exp=0", bus.out_valid); end
    n_cmp++; if (bus.stat_ops !== 32'd0 || bus.out_result !== '0)
      begin n_bad++; $display("[TB] FAIL rststall_clear got=%0d/%h exp=0/0", bus.stat_ops, bus.out_result); end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    clear_lanes();
    act_t = 4'hF;
    for (int k = 0; k < NL; k++) begin op_t[k] = OP_READ; grp_t[k] = 3'(k); end
    drive_beat();
    n_cmp++; if (bus.out_result !== '0 || bus.stat_ops !== 32'd4)
      begin n_bad++; $display("[TB] FAIL rststall_bank got=%h/%0d exp=0/4", bus.out_result, bus.stat_ops); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_chain();
    test_wrap();
    test_backpressure();
    test_inactive_reserved();
    test_bank_clear();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
